ccx_chunk_responder: RTL and testbench

- Off-chip/companion end of the chunked CCX custom-instruction interface driven by the exotiny core.
- Receives rs_a/rs_b operands as CHUNKSIZE-bit chunks, LSB chunk first, and buffers them into full XLEN words.
- Executes one of four operations selected by the core, then streams the result back chunk-serially with a response strobe.
- Used as the reference accelerator on the test board and as the bench model for core-side CCX verification.

---
 rtl/ccx_pkg.sv | 22 ++
 rtl/ccx_alu.sv | 44 ++++
 rtl/ccx_chunk_responder.sv | 157 +++++++++++++++
 tb/tb_ccx_chunk_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccx_pkg.sv
// Shared CCX definitions: FSM states, operation encodings and default widths.
// Used by both the core-side CCX logic and the companion chunk responder.
package ccx_pkg;

    localparam int CCX_XLEN      = 32;
    localparam int CCX_CHUNKSIZE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECV = 2'b01,
        CALC = 2'b10,
        SEND = 2'b11
    } ccx_state_e;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        XOR  = 2'b01,
        ROL  = 2'b10,
        POPC = 2'b11
    } ccx_op_e;

endpackage

// File: rtl/ccx_alu.sv
// CCX operation datapath: add, xor, rotate-left, combined popcount.
// Latency: combinational; backpressure: none.
module ccx_alu
    import ccx_pkg::*;
#(
    parameter int XLEN = CCX_XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  ccx_op_e         op,
    output logic [XLEN-1:0] res
);

    localparam int SHW = $clog2(XLEN);
    // Holds popcount(a)+popcount(b) up to 2*XLEN without overflow.
    localparam int PCW = $clog2(XLEN) + 2;

    logic [SHW-1:0]    shamt;
    logic [2*XLEN-1:0] rol2;
    logic [PCW-1:0]    pcnt;

    assign shamt = b[SHW-1:0];
    // Rotate by shifting a doubled copy; the upper half is the rotated word.
    assign rol2  = {a, a} << shamt;

    always_comb begin
        pcnt = '0;
        for (int i = 0; i < XLEN; i++) begin
            pcnt = pcnt + PCW'(a[i]) + PCW'(b[i]);
        end
    end

    always_comb begin
        res = '0;
        case (op)
            ADD:  res = a + b;
            XOR:  res = a ^ b;
            ROL:  res = rol2[2*XLEN-1:XLEN];
            POPC: res = XLEN'(pcnt);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/ccx_chunk_responder.sv
// Chunk-serial CCX responder: gathers A/B chunks, runs ccx_alu, streams the result back.
// Latency: first result beat CALC_LAT+1 cycles after last req beat; backpressure: none, stray req only flags err_o.
module ccx_chunk_responder
    import ccx_pkg::*;
#(
    parameter int XLEN      = CCX_XLEN,
    parameter int CHUNKSIZE = CCX_CHUNKSIZE,
    parameter int CALC_LAT  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic [CHUNKSIZE-1:0] ccx_rs_a_i,
    input  logic [CHUNKSIZE-1:0] ccx_rs_b_i,
    input  logic [1:0]           ccx_sel_i,
    input  logic                 ccx_req_i,
    output logic [CHUNKSIZE-1:0] ccx_res_o,
    output logic                 ccx_resp_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int NCHUNK = XLEN / CHUNKSIZE;
    localparam int CW     = $clog2(NCHUNK);
    localparam int LW     = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCHUNK - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(CALC_LAT - 1);

    ccx_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [LW-1:0]       lat_q, lat_d;
    logic                err_d;
    logic [CHUNKSIZE-1:0] res_d;
    logic                resp_d;
    logic                cap, clr, latch_op, load_res, shift_res;

    logic [XLEN-1:0]     a_q, b_q, res_sh_q, alu_res;
    ccx_op_e             op_q;

    ccx_alu #(.XLEN(XLEN)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .res (alu_res)
    );

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        err_d     = err_o;
        res_d     = '0;
        resp_d    = 1'b0;
        cap       = 1'b0;
        clr       = 1'b0;
        latch_op  = 1'b0;
        load_res  = 1'b0;
        shift_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (ccx_req_i) begin
                    cap      = 1'b1;
                    latch_op = 1'b1;
                    cnt_d    = CW'(1);
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (ccx_req_i) begin
                    cap = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        lat_d   = '0;
                        state_d = CALC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Short burst: drop the partial operands and flag it.
                    err_d   = 1'b1;
                    clr     = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (ccx_req_i) err_d = 1'b1;
                if (lat_q == LAT_LAST) begin
                    load_res = 1'b1;
                    res_d    = alu_res[CHUNKSIZE-1:0];
                    resp_d   = 1'b1;
                    lat_d    = '0;
                    cnt_d    = '0;
                    state_d  = SEND;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            SEND: begin
                if (ccx_req_i) err_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    res_d     = res_sh_q[CHUNKSIZE-1:0];
                    shift_res = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q      <= '0;
            lat_q      <= '0;
            err_o      <= 1'b0;
            ccx_res_o  <= '0;
            ccx_resp_o <= 1'b0;
            busy_o     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ADD;
            res_sh_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            err_o      <= err_d;
            ccx_res_o  <= res_d;
            ccx_resp_o <= resp_d;
            busy_o     <= (state_d != IDLE);
            if (latch_op) op_q <= ccx_op_e'(ccx_sel_i);
            // Chunks enter at the top, so chunk 0 ends up at the LSB after NCHUNK beats.
            if (clr) begin
                a_q <= '0;
                b_q <= '0;
            end else if (cap) begin
                a_q <= {ccx_rs_a_i, a_q[XLEN-1:CHUNKSIZE]};
                b_q <= {ccx_rs_b_i, b_q[XLEN-1:CHUNKSIZE]};
            end
            if (load_res) begin
                res_sh_q <= alu_res >> CHUNKSIZE;
            end else if (shift_res) begin
                res_sh_q <= res_sh_q >> CHUNKSIZE;
            end
        end
    end

endmodule

// File: tb/tb_ccx_chunk_responder.sv
// Bench for ccx_chunk_responder: vector table through a scoreboard, plus abort, stray-req and reset sequences.
module tb_ccx_chunk_responder;

    localparam int XLEN     = 32;
    localparam int CS       = 4;
    localparam int CALC_LAT = 1;
    localparam int NCHUNK   = XLEN / CS;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [CS-1:0] rs_a  = '0;
    logic [CS-1:0] rs_b  = '0;
    logic [1:0]    sel   = '0;
    logic          req   = 1'b0;
    logic [CS-1:0] res;
    logic          resp, busy, err;

    ccx_chunk_responder #(.XLEN(XLEN), .CHUNKSIZE(CS), .CALC_LAT(CALC_LAT)) dut (
        .clk_i      (clk),
        .rst_in     (rst_n),
        .ccx_rs_a_i (rs_a),
        .ccx_rs_b_i (rs_b),
        .ccx_sel_i  (sel),
        .ccx_req_i  (req),
        .ccx_res_o  (res),
        .ccx_resp_o (resp),
        .busy_o     (busy),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int resp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] res;
        int              cyc;
    } exp_t;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [1:0]      sel;
        logic [XLEN-1:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [1:0] s);
        logic [XLEN-1:0] r;
        case (s)
            2'd0: r = a + b;
            2'd1: r = a ^ b;
            2'd2: begin
                r = a;
                for (int i = 0; i < int'(b[4:0]); i++) r = {r[XLEN-2:0], r[XLEN-1]};
            end
            default: r = XLEN'($countones(a) + $countones(b));
        endcase
        return r;
    endfunction

    // Monitor: reassemble each result stream and compare against the scoreboard head.
    logic            collecting = 1'b0;
    int              k = 0;
    logic [XLEN-1:0] word = '0;
    exp_t            cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            collecting = 1'b0;
            sb.delete();
        end else begin
            if (resp) begin
                resp_cnt++;
                if (collecting) begin
                    check("resp_mid_stream", resp, 0);
                end else if (sb.size() == 0) begin
                    check("resp_unexpected", resp, 0);
                end else begin
                    cur = sb.pop_front();
                    check("resp_latency", cyc, cur.cyc);
                    collecting = 1'b1;
                    k = 0;
                    word = '0;
                end
            end else if (!collecting) begin
                check("res_idle_zero", res, 0);
            end
            if (collecting) begin
                word[k*CS +: CS] = res;
                k++;
                if (k == NCHUNK) begin
                    collecting = 1'b0;
                    check("result_word", word, cur.res);
                end
            end
        end
    end

    task automatic send(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [1:0] s,
                        input logic [XLEN-1:0] exp, input int nbeats, input bit push);
        for (int i = 0; i < nbeats; i++) begin
            @(posedge clk); #1;
            req  = 1'b1;
            rs_a = a[i*CS +: CS];
            rs_b = b[i*CS +: CS];
            sel  = (i == 0) ? s : 2'($urandom);
            if (push && i == NCHUNK - 1) sb.push_back('{res: exp, cyc: cyc + CALC_LAT + 1});
        end
        @(posedge clk); #1;
        req  = 1'b0;
        rs_a = '0;
        rs_b = '0;
        sel  = '0;
    endtask

    task automatic wait_resp();
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp) begin
                found = 1'b1;
                break;
            end
        end
        check("resp_seen", found, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !collecting) break;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int rc;
        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 2'd0, 32'h0000_0000};
        vecs[1] = '{32'h1234_5678, 32'hFFFF_0000, 2'd1, 32'hEDCB_5678};
        vecs[2] = '{32'h8000_0001, 32'h0000_0004, 2'd2, 32'h0000_0018};
        vecs[3] = '{32'h0000_00FF, 32'h0000_000F, 2'd3, 32'h0000_000C};
        for (int i = 4; i < 8; i++) begin
            vecs[i].a   = $urandom;
            vecs[i].b   = $urandom;
            vecs[i].sel = 2'(i - 4);
            vecs[i].exp = model(vecs[i].a, vecs[i].b, vecs[i].sel);
        end

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_res", res, 0);
        check("reset_resp", resp, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        rst_n = 1'b1;

        // Vectors issued back-to-back: next req lands the cycle after the last SEND beat.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp, NCHUNK, 1'b1);
            check("busy_in_calc", busy, 1);
            repeat (CALC_LAT + NCHUNK - 1) @(posedge clk);
        end
        drain();
        check("err_after_table", err, 0);

        // Stray req during SEND.
        send(vecs[1].a, vecs[1].b, vecs[1].sel, vecs[1].exp, NCHUNK, 1'b1);
        wait_resp();
        @(posedge clk); #1;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        drain();
        check("err_stray_req", err, 1);
        @(posedge clk); #1;
        check("busy_after_stray", busy, 0);

        // Async reset on SEND beat 3.
        send(vecs[1].a, vecs[1].b, vecs[1].sel, vecs[1].exp, NCHUNK, 1'b1);
        wait_resp();
        repeat (3) @(posedge clk);
        #2;
        check("send_beat3_chunk", res, 32'h5);
        rst_n = 1'b0;
        #1;
        check("midreset_res", res, 0);
        check("midreset_resp", resp, 0);
        check("midreset_busy", busy, 0);
        check("midreset_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(vecs[2].a, vecs[2].b, vecs[2].sel, vecs[2].exp, NCHUNK, 1'b1);
        drain();
        check("err_after_reset_txn", err, 0);

        // Abort after 3 beats, then a clean XOR.
        rc = resp_cnt;
        send(vecs[0].a, vecs[0].b, vecs[0].sel, vecs[0].exp, 3, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_resp", resp_cnt, rc);
        check("abort_err", err, 1);
        check("abort_busy", busy, 0);
        send(vecs[1].a, vecs[1].b, vecs[1].sel, vecs[1].exp, NCHUNK, 1'b1);
        drain();
        check("err_sticky", err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
